// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the multicycle signed divider controller.
// State encodings and the fixed iteration count.
package div_ctrl_pkg;

   localparam int unsigned ITER_N = 32;

   typedef enum logic [2:0] {
      StIdle = 3'd0,
      StZero = 3'd1,
      StNegA = 3'd2,
      StNegB = 3'd3,
      StIter = 3'd4,
      StFix  = 3'd5
   } state_e;

endpackage

// File: rtl/subtract_32.sv
// 32-bit subtractor: diff_o = a_i - b_i.
// The carry-out c32_o is high when there is no borrow, i.e. a_i >= b_i unsigned.
module subtract_32 (
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [31:0] diff_o,
   output logic        c32_o
);

   logic [32:0] sum;

   // a + ~b + 1 keeps the carry as a no-borrow flag
   assign sum    = {1'b0, a_i} + {1'b0, ~b_i} + 33'd1;
   assign diff_o = sum[31:0];
   assign c32_o  = sum[32];

endmodule

// File: rtl/div_ctrl_32.sv
// Multicycle signed 32-bit divider: negate operands, 32 restoring iterations,
// then sign-correct the quotient, all through one shared subtractor.
module div_ctrl_32
   import div_ctrl_pkg::*;
#(
   parameter int unsigned ITER_N = div_ctrl_pkg::ITER_N
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ctrl_DIV,
   input  logic [31:0] data_operandA,
   input  logic [31:0] data_operandB,
   output logic [31:0] data_result,
   output logic        data_exception,
   output logic        data_resultRDY
);

   state_e      state_q;
   logic [31:0] dvd_q;
   logic [31:0] rem_q;
   logic [31:0] dvs_q;
   logic        neg_q;
   logic [5:0]  cnt_q;

   logic [31:0] sub_a;
   logic [31:0] sub_b;
   logic [31:0] diff;
   logic        c32;

   // rem_q never exceeds the divisor magnitude (<= 2^31), so its MSB stays clear
   logic        unused_rem_msb;
   assign unused_rem_msb = rem_q[31];

   always_comb begin
      sub_a = 32'd0;
      sub_b = dvd_q;
      unique case (state_q)
         StNegB: sub_b = dvs_q;
         StIter: begin
            sub_a = {rem_q[30:0], dvd_q[31]};
            sub_b = dvs_q;
         end
         default: ;
      endcase
   end

   subtract_32 u_sub (
      .a_i    (sub_a),
      .b_i    (sub_b),
      .diff_o (diff),
      .c32_o  (c32)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q        <= StIdle;
         dvd_q          <= 32'd0;
         rem_q          <= 32'd0;
         dvs_q          <= 32'd0;
         neg_q          <= 1'b0;
         cnt_q          <= 6'd0;
         data_result    <= 32'd0;
         data_exception <= 1'b0;
         data_resultRDY <= 1'b0;
      end else begin
         data_resultRDY <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (ctrl_DIV) begin
                  dvd_q   <= data_operandA;
                  dvs_q   <= data_operandB;
                  neg_q   <= data_operandA[31] ^ data_operandB[31];
                  rem_q   <= 32'd0;
                  cnt_q   <= 6'd0;
                  state_q <= (data_operandB == 32'd0) ? StZero : StNegA;
               end
            end
            StZero: begin
               data_result    <= 32'd0;
               data_exception <= 1'b1;
               data_resultRDY <= 1'b1;
               state_q        <= StIdle;
            end
            StNegA: begin
               if (dvd_q[31]) dvd_q <= diff;
               state_q <= StNegB;
            end
            StNegB: begin
               if (dvs_q[31]) dvs_q <= diff;
               state_q <= StIter;
            end
            StIter: begin
               if (c32) begin
                  rem_q <= diff;
                  dvd_q <= {dvd_q[30:0], 1'b1};
               end else begin
                  rem_q <= {rem_q[30:0], dvd_q[31]};
                  dvd_q <= {dvd_q[30:0], 1'b0};
               end
               cnt_q <= cnt_q + 6'd1;
               if (cnt_q == 6'(ITER_N - 1)) state_q <= StFix;
            end
            StFix: begin
               data_result    <= neg_q ? diff : dvd_q;
               data_exception <= 1'b0;
               data_resultRDY <= 1'b1;
               state_q        <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_div_ctrl_32.sv
// Directed self-checking bench for div_ctrl_32: latency, signs, divide-by-zero,
// overflow wrap, ignored starts, back-to-back restart and mid-operation reset.
module tb_div_ctrl_32;

   logic        clock;
   logic        reset;
   logic        ctrl_DIV;
   logic [31:0] data_operandA;
   logic [31:0] data_operandB;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;

   int n_cmp;
   int n_bad;
   int lat;
   int hits;

   div_ctrl_32 dut (
      .clock          (clock),
      .reset          (reset),
      .ctrl_DIV       (ctrl_DIV),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Drive a start pulse; returns at the falling edge after the start edge (edge 0).
   task automatic launch(input logic [31:0] a, input logic [31:0] b);
      @(negedge clock);
      data_operandA = a;
      data_operandB = b;
      ctrl_DIV      = 1'b1;
      @(negedge clock);
      ctrl_DIV = 1'b0;
   endtask

   // Sample after each edge from first_n onward; lat = first edge with RDY, -1 if none.
   task automatic wait_rdy(input int first_n, output int l);
      l = -1;
      for (int n = first_n; n <= 80; n++) begin
         @(negedge clock);
         if (data_resultRDY === 1'b1) begin
            l = n;
            break;
         end
      end
   endtask

   task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_exc, input int exp_lat);
      int l;
      launch(a, b);
      check({tag, " rdy before done"}, {31'd0, data_resultRDY}, 32'd0);
      wait_rdy(1, l);
      check({tag, " latency"}, l, exp_lat);
      check({tag, " result"}, data_result, exp_res);
      check({tag, " exception"}, {31'd0, data_exception}, {31'd0, exp_exc});
      @(negedge clock);
      check({tag, " strobe width"}, {31'd0, data_resultRDY}, 32'd0);
      check({tag, " result hold"}, data_result, exp_res);
   endtask

   initial begin
      n_cmp         = 0;
      n_bad         = 0;
      reset         = 1'b0;
      ctrl_DIV      = 1'b0;
      data_operandA = 32'd0;
      data_operandB = 32'd0;

      #2 reset = 1'b1;
      #1;
      check("reset result", data_result, 32'd0);
      check("reset exception", {31'd0, data_exception}, 32'd0);
      check("reset rdy", {31'd0, data_resultRDY}, 32'd0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;

      run_div("100/7", 32'd100, 32'd7, 32'd14, 1'b0, 35);
      run_div("-100/7", 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 1'b0, 35);
      run_div("-100/-7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 1'b0, 35);
      run_div("7/-100", 32'd7, 32'hFFFF_FF9C, 32'd0, 1'b0, 35);
      run_div("7/0", 32'd7, 32'd0, 32'd0, 1'b1, 1);
      run_div("min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 35);
      run_div("min/1", 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0, 35);
      run_div("max/2", 32'h7FFF_FFFF, 32'd2, 32'h3FFF_FFFF, 1'b0, 35);

      // Start pulse while busy is dropped; restart on the RDY cycle is accepted
      launch(32'd100, 32'd7);
      repeat (9) @(negedge clock);
      data_operandA = 32'd50;
      data_operandB = 32'd5;
      ctrl_DIV      = 1'b1;
      @(negedge clock);
      ctrl_DIV = 1'b0;
      wait_rdy(11, lat);
      check("ignored start latency", lat, 35);
      check("ignored start result", data_result, 32'd14);
      data_operandA = 32'd50;
      data_operandB = 32'd5;
      ctrl_DIV      = 1'b1;
      @(negedge clock);
      ctrl_DIV = 1'b0;
      check("b2b strobe width", {31'd0, data_resultRDY}, 32'd0);
      wait_rdy(1, lat);
      check("b2b latency", lat, 35);
      check("b2b result", data_result, 32'd10);

      // Asynchronous reset in the middle of cycle 12 aborts the operation
      launch(32'd100, 32'd7);
      repeat (11) @(negedge clock);
      @(posedge clock);
      #2 reset = 1'b1;
      #1;
      check("abort result", data_result, 32'd0);
      check("abort exception", {31'd0, data_exception}, 32'd0);
      check("abort rdy", {31'd0, data_resultRDY}, 32'd0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      hits  = 0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clock);
         if (data_resultRDY !== 1'b0) hits++;
      end
      check("no strobe after abort", hits, 0);
      run_div("9/3 after reset", 32'd9, 32'd3, 32'd3, 1'b0, 35);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
